alu_mult_ctrl: RTL and testbench

ALU_MULT_CTRL -- requirements
Module: alu_mult_ctrl

---
 rtl/alu_mult_ctrl.sv | 106 ++++++++++
 tb/tb_alu_mult_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_mult_ctrl.sv
// Shift-add multiply controller that drives an external 32-bit combinational ALU, 33 cycles start-to-done.
// Optional macro MULT_ZERO_SKIP_EN: a zero operand finishes in one cycle with product 0.
module alu_mult_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   mcand,
  input  logic [WIDTH-1:0]   mplier,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic [WIDTH-1:0]   alu_a,
  output logic [WIDTH-1:0]   alu_b,
  output logic               alu_binvert,
  output logic               alu_carryin,
  output logic [1:0]         alu_op,
  input  logic [WIDTH-1:0]   alu_result,
  input  logic               alu_carryout
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t               r_state;
  state_t               w_next;
  logic [WIDTH-1:0]     r_mc;
  logic [WIDTH-1:0]     r_hi;
  logic [WIDTH-1:0]     r_lo;
  logic [CW-1:0]        r_cnt;
  logic [2*WIDTH-1:0]   r_product;
  logic [WIDTH-1:0]     w_hi_nxt;
  logic [WIDTH-1:0]     w_lo_nxt;
  logic                 w_zero;

`ifdef MULT_ZERO_SKIP_EN
  assign w_zero = (mcand == '0) || (mplier == '0);
`else
  assign w_zero = 1'b0;
`endif

  // The ALU sum carries into hi; its carry becomes the new top bit of the 2W shift.
  always_comb begin
    w_hi_nxt = r_hi;
    w_lo_nxt = r_lo;
    if (r_lo[0]) begin
      {w_hi_nxt, w_lo_nxt} = {alu_carryout, alu_result, r_lo[WIDTH-1:1]};
    end else begin
      {w_hi_nxt, w_lo_nxt} = {1'b0, r_hi, r_lo[WIDTH-1:1]};
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = w_zero ? S_DONE : S_RUN;
      S_RUN:   if (r_cnt == LAST) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_mc      <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_cnt     <= '0;
      r_product <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_mc  <= mcand;
            r_hi  <= '0;
            r_lo  <= mplier;
            r_cnt <= '0;
            if (w_zero) r_product <= '0;
          end
        end
        S_RUN: begin
          r_hi  <= w_hi_nxt;
          r_lo  <= w_lo_nxt;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST) r_product <= {w_hi_nxt, w_lo_nxt};
        end
        default: ;
      endcase
    end
  end

  assign busy        = (r_state != S_IDLE);
  assign done        = (r_state == S_DONE);
  assign product     = r_product;
  assign alu_a       = r_hi;
  assign alu_b       = r_mc;
  assign alu_binvert = 1'b0;
  assign alu_carryin = 1'b0;
  assign alu_op      = 2'b10;

endmodule

// File: tb/tb_alu_mult_ctrl.sv
// Bench for alu_mult_ctrl: behavioural ALU, countdown/product model, per-cycle compare, directed and random ops.
module tb_alu_mult_ctrl;

`ifdef MULT_ZERO_SKIP_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, start;
  logic [31:0] mcand, mplier;
  logic        busy, done;
  logic [63:0] product;
  logic [31:0] alu_a, alu_b, alu_result;
  logic        alu_binvert, alu_carryin, alu_carryout;
  logic [1:0]  alu_op;
  logic [32:0] alu_sum;

  alu_mult_ctrl #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .mcand(mcand), .mplier(mplier),
    .busy(busy), .done(done), .product(product),
    .alu_a(alu_a), .alu_b(alu_b), .alu_binvert(alu_binvert),
    .alu_carryin(alu_carryin), .alu_op(alu_op),
    .alu_result(alu_result), .alu_carryout(alu_carryout)
  );

  // Shared ALU in add mode
  assign alu_sum      = {1'b0, alu_a} + {1'b0, alu_b};
  assign alu_result   = alu_sum[31:0];
  assign alu_carryout = alu_sum[32];

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endtask

  // Model: remaining busy cycles; done is the last busy cycle.
  bit          m_valid = 1'b0;
  bit          m_a0 = 1'b0;
  int          m_left = 0;
  int          m_completed = 0;
  logic [63:0] m_prod = '0;
  logic [63:0] m_exp = '0;
  logic [31:0] m_mc = '0;

  always @(posedge clk) begin
    m_a0 = 1'b0;
    if (rst) begin
      m_valid = 1'b1;
      m_left  = 0;
      m_prod  = '0;
      m_mc    = '0;
      m_a0    = 1'b1;
    end else if (m_left == 0) begin
      if (start) begin
        m_mc  = mcand;
        m_exp = 64'(mcand) * 64'(mplier);
        if (SKIP && (mcand == 0 || mplier == 0)) begin
          m_left = 1;
          m_prod = '0;
          m_completed++;
        end else begin
          m_left = 33;
          m_a0   = 1'b1;
        end
      end
    end else begin
      m_left--;
      if (m_left == 1) begin
        m_prod = m_exp;
        m_completed++;
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("busy", 64'(busy), 64'(m_left > 0));
      chk("done", 64'(done), 64'(m_left == 1));
      chk("product", product, m_prod);
      chk("alu_b", 64'(alu_b), 64'(m_mc));
      chk("alu_ctrl", 64'({alu_op, alu_binvert, alu_carryin}), 64'(4'b1000));
      if (m_a0) chk("alu_a_zero", 64'(alu_a), 64'd0);
    end
  end

  task automatic do_op(input logic [31:0] a, input logic [31:0] b, output int lat, output int nb);
    int g;
    g = 0;
    while (busy && g < 100) begin
      @(negedge clk);
      g++;
    end
    mcand = a;
    mplier = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    nb = 0;
    while (!done && lat < 100) begin
      if (busy) nb++;
      @(negedge clk);
      lat++;
    end
    if (busy) nb++;
  endtask

  int lat, nb, g, cyc, target;

  initial begin
    rst = 1'b1; start = 1'b0; mcand = '0; mplier = '0;
    repeat (3) @(negedge clk);
    chk("rst_product", product, 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_alu_a", 64'(alu_a), 64'd0);
    chk("rst_alu_b", 64'(alu_b), 64'd0);
    rst = 1'b0;

    do_op(32'd3, 32'd5, lat, nb);
    chk("lat_3x5", 64'(lat), 64'd33);
    chk("busy_cycles_3x5", 64'(nb), 64'd33);
    chk("prod_3x5", product, 64'h0000_0000_0000_000F);

    do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, nb);
    chk("lat_max", 64'(lat), 64'd33);
    chk("prod_max", product, 64'hFFFF_FFFE_0000_0001);

    // Starts at cycles 5 and 33 land while busy and must be ignored
    g = 0;
    while (busy && g < 100) begin @(negedge clk); g++; end
    mcand = 32'h0001_0000; mplier = 32'h0001_0001; start = 1'b1;
    @(negedge clk);
    for (int n = 1; n <= 33; n++) begin
      if (n == 33) begin
        chk("ign_done", 64'(done), 64'd1);
        chk("ign_prod", product, 64'h0000_0001_0001_0000);
      end
      if (n == 5 || n == 33) begin
        start = 1'b1; mcand = 32'hDEAD_0001; mplier = 32'hBEEF_0002;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    chk("ign_idle", 64'(busy), 64'd0);
    chk("ign_hold", product, 64'h0000_0001_0001_0000);
    mcand = 32'd2; mplier = 32'd21; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("accept_n34", 64'(busy), 64'd1);
    g = 0;
    while (!done && g < 100) begin @(negedge clk); g++; end
    chk("prod_2x21", product, 64'd42);

    // Reset in RUN cycle 10
    @(negedge clk);
    mcand = 32'h1111; mplier = 32'h2222; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_prod", product, 64'd0);
    do_op(32'd7, 32'd9, lat, nb);
    chk("prod_7x9", product, 64'd63);

    do_op(32'd0, 32'h1234, lat, nb);
    chk("lat_zero", 64'(lat), SKIP ? 64'd1 : 64'd33);
    chk("busy_cycles_zero", 64'(nb), SKIP ? 64'd1 : 64'd33);
    chk("prod_zero", product, 64'd0);

    // Random traffic: starts at any time, rare resets, occasional zero/max operands
    target = m_completed + 1000;
    cyc = 0;
    while (m_completed < target && cyc < 60000) begin
      start = 1'($urandom % 2);
      case ($urandom % 16)
        0:       mcand = 32'd0;
        1:       mcand = 32'hFFFF_FFFF;
        default: mcand = $urandom();
      endcase
      case ($urandom % 16)
        0:       mplier = 32'd0;
        1:       mplier = 32'hFFFF_FFFF;
        default: mplier = $urandom();
      endcase
      rst = ($urandom_range(2999, 0) == 0);
      @(negedge clk);
      cyc++;
    end
    rst = 1'b0;
    start = 1'b0;
    chk("random_ops_completed", 64'(m_completed >= target), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
